cache_axi_rd_arbiter: RTL

Shares one AXI4 read channel (AR + R) between the instruction cache and the data cache.
- Grants one requester at a time and holds the grant from the AR handshake through the final R beat (rlast).
- Steers AR signals out to the bus and R beats back to the owner only.
- Sits between the two caches and the top-level AXI master interface; only one read burst is ever outstanding.

---
 rtl/cache_axi_rd_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/cache_axi_rd_arbiter.sv
// cache_axi_rd_arbiter: shares one AXI4 read channel (AR + R) between the
// instruction cache and the data cache. One burst is outstanding at a time.
// The grant is held from the AR handshake through the final R beat.
// Optional build macro ARB_ROUND_ROBIN_EN: on a tie, alternate owners by
// granting the requester that did not own the last completed burst.
// Without the macro the dcache always wins a tie.
module cache_axi_rd_arbiter #(
  parameter logic [3:0] I_ID = 4'd0,
  parameter logic [3:0] D_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  // icache side
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  // dcache side
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  // AXI master read channel
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arid,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rlast_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic       owner_r;        // 0 = icache, 1 = dcache
  logic       owner_nxt_s;
  logic       grant_owner_s;
  logic [7:0] beat_cnt_r;
  logic [7:0] len_q_r;
  logic       rlast_err_r;
  logic       own_arvalid_s;
  logic       own_rready_s;
  logic       ar_hs_s;
  logic       r_hs_s;
  logic       r_done_s;

`ifdef ARB_ROUND_ROBIN_EN
  logic       last_owner_r;

  // Tie-break: on contention grant whoever did not own the last burst
  always_comb begin
    grant_owner_s = 1'b0;
    if (d_arvalid && i_arvalid) begin
      grant_owner_s = ~last_owner_r;
    end else if (d_arvalid) begin
      grant_owner_s = 1'b1;
    end else begin
      grant_owner_s = 1'b0;
    end
  end

  // Remember the owner of the most recently completed burst
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_r <= 1'b0;
    end else if (r_done_s) begin
      last_owner_r <= owner_r;
    end else begin
      last_owner_r <= last_owner_r;
    end
  end
`else
  // Tie-break: fixed priority, dcache ahead of icache
  always_comb begin
    grant_owner_s = 1'b0;
    if (d_arvalid) begin
      grant_owner_s = 1'b1;
    end else begin
      grant_owner_s = 1'b0;
    end
  end
`endif

  // Owner-selected request/accept signals and handshake qualifiers
  always_comb begin
    own_arvalid_s = owner_r ? d_arvalid : i_arvalid;
    own_rready_s  = owner_r ? d_rready  : i_rready;
    ar_hs_s       = (state_r == ADDR) && own_arvalid_s && arready;
    r_hs_s        = (state_r == DATA) && rvalid && own_rready_s;
    r_done_s      = r_hs_s && rlast;
  end

  // Next-state and owner selection
  always_comb begin
    state_nxt_s = state_r;
    owner_nxt_s = owner_r;
    case (state_r)
      IDLE: begin
        if (d_arvalid || i_arvalid) begin
          state_nxt_s = ADDR;
          owner_nxt_s = grant_owner_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ADDR: begin
        if (!own_arvalid_s) begin
          state_nxt_s = IDLE;   // requester withdrew, nothing issued
        end else if (arready) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = ADDR;
        end
      end
      DATA: begin
        if (r_done_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DATA;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output steering: AR toward the bus in ADDR, R toward the owner in DATA
  always_comb begin
    araddr    = owner_r ? d_araddr : i_araddr;
    arlen     = owner_r ? d_arlen  : i_arlen;
    arid      = owner_r ? D_ID     : I_ID;
    arsize    = 3'b010;
    arburst   = 2'b01;
    arvalid   = 1'b0;
    i_arready = 1'b0;
    d_arready = 1'b0;
    rready    = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rlast   = 1'b0;
    d_rlast   = 1'b0;
    i_rdata   = rdata;
    d_rdata   = rdata;
    case (state_r)
      ADDR: begin
        arvalid   = own_arvalid_s;
        i_arready = ~owner_r & arready;
        d_arready =  owner_r & arready;
      end
      DATA: begin
        rready   = own_rready_s;
        i_rvalid = ~owner_r & rvalid;
        d_rvalid =  owner_r & rvalid;
        i_rlast  = ~owner_r & rlast;
        d_rlast  =  owner_r & rlast;
      end
      default: begin
        arvalid = 1'b0;
      end
    endcase
  end

  // State, owner, burst length, beat counter and beat-count error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= 1'b0;
      beat_cnt_r  <= 8'd0;
      len_q_r     <= 8'd0;
      rlast_err_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      owner_r <= owner_nxt_s;
      if (ar_hs_s) begin
        len_q_r    <= arlen;
        beat_cnt_r <= 8'd0;
      end else if (r_hs_s) begin
        len_q_r    <= len_q_r;
        beat_cnt_r <= beat_cnt_r + 8'd1;
      end else begin
        len_q_r    <= len_q_r;
        beat_cnt_r <= beat_cnt_r;
      end
      // beat_cnt still holds the pre-increment count on the rlast beat,
      // so a correct burst of arlen+1 beats has beat_cnt == len_q here
      rlast_err_r <= r_done_s && (beat_cnt_r != len_q_r);
    end
  end

  assign rlast_err = rlast_err_r;

endmodule
